// File: rtl/mmio_axil_bridge_if.sv
// mmio_axil_bridge_if
// AXI4-Lite bus between the MMIO bridge (master) and the interconnect (slave).
// Channels:
//   AW : awaddr[31:0], awvalid  -> master ; awready <- slave
//   W  : wdata[31:0], wstrb[3:0], wvalid -> master ; wready <- slave
//   B  : bresp[1:0], bvalid <- slave ; bready -> master
//   AR : araddr[31:0], arvalid -> master ; arready <- slave
//   R  : rdata[31:0], rresp[1:0], rvalid <- slave ; rready -> master
interface mmio_axil_bridge_if;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/mmio_axil_bridge.sv
// mmio_axil_bridge
// Turns the load/store stage's level-held uncached MMIO request into single
// AXI4-Lite transactions, one in flight at a time.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   rw_valid_o          request, held high until completion
//   rw_write_o          1 = store, 0 = load
//   rw_addr_i           byte address (low 32 bits drive AXI)
//   rw_w_data_i         store data, LSB-aligned
//   rw_size_i           log2 bytes, bits [1:0] used
//   rw_valid_i          one-cycle completion pulse
//   data_read_i         right-aligned load data, held until next load completes
//   data_ready_to_read  high while idle
//   axi                 AXI4-Lite master channels
//   err_o, err_addr_o   sticky error flag / first error address
// Optional feature macro: MMIO_ERR_TRAP_EN (error trap on nonzero bresp/rresp).
module mmio_axil_bridge #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rw_valid_o,
  input  logic              rw_write_o,
  input  logic [ADDR_W-1:0] rw_addr_i,
  input  logic [DATA_W-1:0] rw_w_data_i,
  input  logic [3:0]        rw_size_i,
  output logic              rw_valid_i,
  output logic [DATA_W-1:0] data_read_i,
  output logic              data_ready_to_read,
  mmio_axil_bridge_if.master axi,
  output logic              err_o,
  output logic [31:0]       err_addr_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_WREQ, S_WRESP, S_RREQ, S_RRESP, S_ACK
  } state_t;

  state_t            r_state, w_next;
  logic [31:0]       r_addr;
  logic [1:0]        r_off;
  logic [1:0]        r_size;
  logic              r_write;
  logic [DATA_W-1:0] r_wdata;
  logic [3:0]        r_wstrb;
  logic              r_aw_done, r_w_done;
  logic [DATA_W-1:0] r_rdata;

  logic [3:0]        w_base;
  logic [3:0]        w_strb;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_rshift;
  logic [DATA_W-1:0] w_rdata;
  logic              w_aw_fire, w_w_fire;

  assign w_aw_fire = axi.awvalid && axi.awready;
  assign w_w_fire  = axi.wvalid && axi.wready;

  // Lane placement of the store; bytes shifted past lane 3 are dropped.
  always_comb begin
    w_base = 4'b1111;
    case (rw_size_i[1:0])
      2'd0:    w_base = 4'b0001;
      2'd1:    w_base = 4'b0011;
      default: w_base = 4'b1111;
    endcase
    w_strb  = w_base << rw_addr_i[1:0];
    w_wdata = rw_w_data_i << {rw_addr_i[1:0], 3'b000};
  end

  // Right-align the returned word and zero bytes above the access size.
  always_comb begin
    w_rshift = axi.rdata >> {r_off, 3'b000};
    w_rdata  = w_rshift;
    case (r_size)
      2'd0:    w_rdata = {24'h0, w_rshift[7:0]};
      2'd1:    w_rdata = {16'h0, w_rshift[15:0]};
      default: w_rdata = w_rshift;
    endcase
  end

  always_comb begin
    w_next      = r_state;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    rw_valid_i  = 1'b0;
    case (r_state)
      S_IDLE:  if (rw_valid_o) w_next = rw_write_o ? S_WREQ : S_RREQ;
      S_WREQ: begin
        axi.awvalid = !r_aw_done;
        axi.wvalid  = !r_w_done;
        if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) w_next = S_WRESP;
      end
      S_WRESP: begin
        axi.bready = 1'b1;
        if (axi.bvalid) w_next = S_ACK;
      end
      S_RREQ: begin
        axi.arvalid = 1'b1;
        if (axi.arready) w_next = S_RRESP;
      end
      S_RRESP: begin
        axi.rready = 1'b1;
        if (axi.rvalid) w_next = S_ACK;
      end
      S_ACK: begin
        rw_valid_i = 1'b1;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign data_ready_to_read = (r_state == S_IDLE);
  assign data_read_i        = r_rdata;
  assign axi.awaddr         = r_addr;
  assign axi.araddr         = r_addr;
  assign axi.wdata          = r_wdata;
  assign axi.wstrb          = r_wstrb;

`ifdef MMIO_ERR_TRAP_EN
  logic        r_err;
  logic [31:0] r_err_addr;
  logic        w_unused;
  assign w_unused   = ^{rw_addr_i[ADDR_W-1:32], rw_size_i[3:2], r_write};
  assign err_o      = r_err;
  assign err_addr_o = r_err_addr;
`else
  logic w_unused;
  assign w_unused   = ^{rw_addr_i[ADDR_W-1:32], rw_size_i[3:2], r_write,
                        axi.bresp, axi.rresp};
  assign err_o      = 1'b0;
  assign err_addr_o = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_addr    <= '0;
      r_off     <= '0;
      r_size    <= '0;
      r_write   <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
      r_rdata   <= '0;
`ifdef MMIO_ERR_TRAP_EN
      r_err      <= 1'b0;
      r_err_addr <= '0;
`endif
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (rw_valid_o) begin
          r_addr    <= rw_addr_i[31:0];
          r_off     <= rw_addr_i[1:0];
          r_size    <= rw_size_i[1:0];
          r_write   <= rw_write_o;
          r_wdata   <= w_wdata;
          r_wstrb   <= w_strb;
          r_aw_done <= 1'b0;
          r_w_done  <= 1'b0;
        end
        S_WREQ: begin
          if (w_aw_fire) r_aw_done <= 1'b1;
          if (w_w_fire)  r_w_done  <= 1'b1;
        end
`ifdef MMIO_ERR_TRAP_EN
        S_WRESP: if (axi.bvalid && axi.bresp != 2'b00) begin
          r_err <= 1'b1;
          if (!r_err) r_err_addr <= r_addr;
        end
        S_RRESP: if (axi.rvalid) begin
          if (axi.rresp != 2'b00) begin
            r_rdata <= '0;
            r_err   <= 1'b1;
            if (!r_err) r_err_addr <= r_addr;
          end else begin
            r_rdata <= w_rdata;
          end
        end
`else
        S_RRESP: if (axi.rvalid) r_rdata <= w_rdata;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_axil_bridge.sv
module tb_mmio_axil_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic        rw_valid_o, rw_write_o;
  logic [63:0] rw_addr_i;
  logic [31:0] rw_w_data_i;
  logic [3:0]  rw_size_i;
  logic        rw_valid_i;
  logic [31:0] data_read_i;
  logic        data_ready_to_read;
  logic        err_o;
  logic [31:0] err_addr_o;

  always #5 clk = ~clk;

  mmio_axil_bridge_if axi();

  mmio_axil_bridge #(.ADDR_W(64), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .rw_valid_o(rw_valid_o), .rw_write_o(rw_write_o),
    .rw_addr_i(rw_addr_i), .rw_w_data_i(rw_w_data_i), .rw_size_i(rw_size_i),
    .rw_valid_i(rw_valid_i), .data_read_i(data_read_i),
    .data_ready_to_read(data_ready_to_read),
    .axi(axi),
    .err_o(err_o), .err_addr_o(err_addr_o)
  );

  int compared = 0;
  int mismatched = 0;
  int ack_cnt = 0;
  int issued = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- AXI slave model ----------------
  int unsigned aw_lat = 0, w_lat = 0, ar_lat = 0;
  int unsigned aw_cnt, w_cnt, ar_cnt;
  logic aw_seen, w_seen, pend_b, pend_r;
  logic r_hold = 1'b0;
  logic [1:0]  resp_val = 2'b00;
  logic [31:0] rdata_val = '0;

  assign axi.awready = axi.awvalid && (aw_cnt >= aw_lat);
  assign axi.wready  = axi.wvalid  && (w_cnt  >= w_lat);
  assign axi.arready = axi.arvalid && (ar_cnt >= ar_lat);
  assign axi.bvalid  = pend_b;
  assign axi.bresp   = resp_val;
  assign axi.rvalid  = pend_r && !r_hold;
  assign axi.rdata   = rdata_val;
  assign axi.rresp   = resp_val;

  always @(posedge clk) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0;
      aw_seen <= 1'b0; w_seen <= 1'b0; pend_b <= 1'b0; pend_r <= 1'b0;
    end else begin
      aw_cnt <= (axi.awvalid && !axi.awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (axi.wvalid  && !axi.wready)  ? w_cnt + 1  : 0;
      ar_cnt <= (axi.arvalid && !axi.arready) ? ar_cnt + 1 : 0;
      if ((aw_seen || (axi.awvalid && axi.awready)) && (w_seen || (axi.wvalid && axi.wready))) begin
        pend_b <= 1'b1; aw_seen <= 1'b0; w_seen <= 1'b0;
      end else begin
        aw_seen <= aw_seen || (axi.awvalid && axi.awready);
        w_seen  <= w_seen  || (axi.wvalid  && axi.wready);
      end
      if (axi.bvalid && axi.bready) pend_b <= 1'b0;
      if (axi.arvalid && axi.arready) pend_r <= 1'b1;
      if (axi.rvalid && axi.rready) pend_r <= 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] q_ack[$];
  logic [31:0] q_aw[$];
  logic [35:0] q_w[$];
  logic [31:0] q_ar[$];

  always @(negedge clk) begin
    if (!rst) begin
      if (rw_valid_i) begin
        ack_cnt++;
        if (q_ack.size() == 0) check("ack_unexpected", 32'd1, 32'd0);
        else check("ack_data", data_read_i, q_ack.pop_front());
      end
      if (axi.awvalid && axi.awready) begin
        if (q_aw.size() == 0) check("aw_unexpected", axi.awaddr, 32'hx);
        else check("awaddr", axi.awaddr, q_aw.pop_front());
      end
      if (axi.wvalid && axi.wready) begin
        if (q_w.size() == 0) check("w_unexpected", axi.wdata, 32'hx);
        else begin
          logic [35:0] e;
          e = q_w.pop_front();
          check("wstrb", {28'h0, axi.wstrb}, {28'h0, e[35:32]});
          check("wdata", axi.wdata, e[31:0]);
        end
      end
      if (axi.arvalid && axi.arready) begin
        if (q_ar.size() == 0) check("ar_unexpected", axi.araddr, 32'hx);
        else check("araddr", axi.araddr, q_ar.pop_front());
      end
    end
  end

  // Issue one request; caller is #1 after a posedge. Returns ack latency in cycles.
  task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [1:0] sz, input logic [31:0] rd,
                       input logic [3:0] exp_strb, input logic [31:0] exp_wd,
                       input logic [31:0] exp_rd, input bit hold, output int lat);
    bit got;
    got = 0;
    lat = -1;
    rdata_val = rd;
    issued++;
    if (wr) begin
      q_aw.push_back(addr);
      q_w.push_back({exp_strb, exp_wd});
    end else begin
      q_ar.push_back(addr);
    end
    q_ack.push_back(exp_rd);
    rw_valid_o  = 1'b1;
    rw_write_o  = wr;
    rw_addr_i   = {32'h0, addr};
    rw_w_data_i = wd;
    rw_size_i   = {2'b00, sz};
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rw_valid_i) begin got = 1; lat = i; break; end
    end
    if (!got) check("ack_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (!hold) rw_valid_o = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  int lat;

  initial begin
    rst = 1'b1; rw_valid_o = 1'b0; rw_write_o = 1'b0;
    rw_addr_i = '0; rw_w_data_i = '0; rw_size_i = '0;
    idle(3);
    check("rst_arvalid", {31'h0, axi.arvalid}, 32'd0);
    check("rst_awvalid", {31'h0, axi.awvalid}, 32'd0);
    check("rst_wvalid",  {31'h0, axi.wvalid},  32'd0);
    check("rst_ready",   {30'h0, axi.bready, axi.rready}, 32'd0);
    check("rst_ack",     {31'h0, rw_valid_i},  32'd0);
    check("rst_data",    data_read_i, 32'h0);
    check("rst_idle",    {31'h0, data_ready_to_read}, 32'd1);
    check("rst_err",     {31'h0, err_o}, 32'd0);
    check("rst_err_addr", err_addr_o, 32'h0);
    rst = 1'b0;
    idle(1);

    // Basic read, minimum latency
    issue(0, 32'hA000_0004, 32'h0, 2'd2, 32'h1234_5678, 4'h0, 32'h0, 32'h1234_5678, 0, lat);
    check("read_latency", lat, 32'd3);
    idle(2);
    check("read_held", data_read_i, 32'h1234_5678);

    // Stores: lane placement, held read data unchanged
    issue(1, 32'hA000_0003, 32'h0000_00AB, 2'd0, 32'h0, 4'b1000, 32'hAB00_0000, 32'h1234_5678, 0, lat);
    check("write_latency", lat, 32'd3);
    issue(1, 32'hA000_0002, 32'h0000_1234, 2'd1, 32'h0, 4'b1100, 32'h1234_0000, 32'h1234_5678, 0, lat);
    issue(1, 32'hA000_0001, 32'h1122_3344, 2'd2, 32'h0, 4'b1110, 32'h2233_4400, 32'h1234_5678, 0, lat);
    check("write_keeps_data", data_read_i, 32'h1234_5678);

    // Sub-word loads: shift and mask
    issue(0, 32'hA000_0006, 32'h0, 2'd0, 32'h1234_5678, 4'h0, 32'h0, 32'h0000_0034, 0, lat);
    issue(0, 32'hA000_0005, 32'h0, 2'd1, 32'hAABB_CCDD, 4'h0, 32'h0, 32'h0000_BBCC, 0, lat);

    // awready three cycles late, wready immediate
    aw_lat = 3;
    fork
      issue(1, 32'hA000_0008, 32'hCAFE_F00D, 2'd2, 32'h0, 4'hF, 32'hCAFE_F00D, 32'h0000_BBCC, 0, lat);
      begin
        bit seen;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
          @(negedge clk);
          if (axi.awvalid) seen = 1;
        end
        check("late_aw_start", {31'h0, seen}, 32'd1);
        check("late_wvalid_c1", {31'h0, axi.wvalid}, 32'd1);
        @(negedge clk);
        check("late_wvalid_c2", {31'h0, axi.wvalid}, 32'd0);
        check("late_awvalid_c2", {31'h0, axi.awvalid}, 32'd1);
        @(negedge clk); @(negedge clk);
        check("late_awvalid_c4", {31'h0, axi.awvalid}, 32'd1);
        @(negedge clk);
        check("late_awvalid_c5", {31'h0, axi.awvalid}, 32'd0);
      end
    join
    check("late_latency", lat, 32'd6);
    aw_lat = 0;

    // Back-to-back: request held across the ack
    issue(0, 32'hA000_0008, 32'h0, 2'd2, 32'h1111_1111, 4'h0, 32'h0, 32'h1111_1111, 1, lat);
    issue(0, 32'hA000_0010, 32'h0, 2'd2, 32'h2222_2222, 4'h0, 32'h0, 32'h2222_2222, 0, lat);
    idle(3);
    check("b2b_ack_count", ack_cnt, issued);

    // Reset while waiting in RRESP
    begin
      bit in_rresp;
      in_rresp = 0;
      r_hold = 1'b1;
      q_ar.push_back(32'hA000_0030);
      rw_valid_o = 1'b1; rw_write_o = 1'b0; rw_addr_i = 64'hA000_0030; rw_size_i = 4'd2;
      for (int i = 0; i < 20 && !in_rresp; i++) begin
        @(negedge clk);
        if (axi.rready) in_rresp = 1;
      end
      check("reach_rresp", {31'h0, in_rresp}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b1; rw_valid_o = 1'b0;
      @(posedge clk); #1;
      check("mid_rst_valids", {27'h0, axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 32'd0);
      check("mid_rst_ack", {31'h0, rw_valid_i}, 32'd0);
      check("mid_rst_data", data_read_i, 32'h0);
      rst = 1'b0; r_hold = 1'b0;
      idle(5);
      check("mid_rst_no_ack", ack_cnt, issued);
    end

`ifdef MMIO_ERR_TRAP_EN
    resp_val = 2'b10;
    issue(0, 32'hA000_0020, 32'h0, 2'd2, 32'hDEAD_BEEF, 4'h0, 32'h0, 32'h0, 0, lat);
    check("err_flag", {31'h0, err_o}, 32'd1);
    check("err_addr", err_addr_o, 32'hA000_0020);
    resp_val = 2'b11;
    issue(0, 32'hA000_0024, 32'h0, 2'd2, 32'hDEAD_BEEF, 4'h0, 32'h0, 32'h0, 0, lat);
    check("err_addr_first", err_addr_o, 32'hA000_0020);
    resp_val = 2'b00;
    issue(0, 32'hA000_0028, 32'h0, 2'd2, 32'h5555_AAAA, 4'h0, 32'h0, 32'h5555_AAAA, 0, lat);
    check("err_sticky", {31'h0, err_o}, 32'd1);
`else
    resp_val = 2'b10;
    issue(0, 32'hA000_0020, 32'h0, 2'd2, 32'hDEAD_BEEF, 4'h0, 32'h0, 32'hDEAD_BEEF, 0, lat);
    check("noerr_flag", {31'h0, err_o}, 32'd0);
    check("noerr_addr", err_addr_o, 32'h0);
    resp_val = 2'b00;
`endif

    idle(3);
    check("total_acks", ack_cnt, issued);
    check("queues_empty", q_ack.size() + q_aw.size() + q_w.size() + q_ar.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mmio_axil_bridge.md
Name: mmio_axil_bridge

Overview:
- Sits directly downstream of the load/store stage's uncached MMIO port (0xA000_0000 region).
- Converts the stage's level-held request (valid, write, addr, wdata, size) into single AXI4-Lite master transactions.
- Returns a one-cycle completion pulse plus read data that is held stable for the stage's registered load-extension logic.
- One transaction in flight at a time; no buffering beyond one request.

Parameters:
- ADDR_W, 64, request address width; the low 32 bits drive AXI addresses.
- DATA_W, 32, AXI data width; fixed at 32, the only value supported.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rw_valid_o  in  1  MMIO request; held high until completion
- rw_write_o  in  1  1 = store, 0 = load; valid with rw_valid_o
- rw_addr_i  in  64  byte address
- rw_w_data_i  in  32  store data, LSB-aligned (not lane-shifted)
- rw_size_i  in  4  log2 bytes; bits [1:0] used
- rw_valid_i  out  1  completion pulse, one cycle
- data_read_i  out  32  load data, right-aligned, held until the next load completes
- data_ready_to_read  out  1  high while the FSM is IDLE
- awaddr out 32, awvalid out 1, awready in 1
- wdata out 32, wstrb out 4, wvalid out 1, wready in 1
- bresp in 2, bvalid in 1, bready out 1
- araddr out 32, arvalid out 1, arready in 1
- rdata in 32, rresp in 2, rvalid in 1, rready out 1
- err_o  out  1  sticky error flag (optional feature)
- err_addr_o  out  32  address of the first error (optional feature)

Behaviour:
- Reset: state=IDLE; all AXI valid and ready outputs 0; rw_valid_i=0; data_read_i=0; data_ready_to_read=1; err_o=0; err_addr_o=0. Reset mid-transaction abandons it immediately, and no ack is produced.
- States: IDLE, WREQ, WRESP, RREQ, RRESP, ACK.
- IDLE, when rw_valid_o=1:
  - Latch addr[31:0], lane offset o=addr[1:0], the write flag, and size s=size[1:0].
  - Go to WREQ for a write, RREQ for a read.
  - A request is sampled only in IDLE.
- Byte strobes and lanes:
  - Base mask: s=0→0001, s=1→0011, s≥2→1111.
  - wstrb = (base mask << o), truncated to 4 bits.
  - wdata = wdata_in << (8*o).
  - Misaligned bytes beyond the word are dropped; no split transaction is issued.
- WREQ:
  - awvalid and wvalid are both asserted the cycle after the request is accepted.
  - Each valid drops independently on its own handshake (aw_done/w_done flags).
  - When both are done, go to WRESP.
- WRESP: bready=1; on bvalid go to ACK.
- RREQ: arvalid=1; on arready go to RRESP.
- RRESP:
  - rready=1.
  - On rvalid, data_read_i <= (rdata >> 8*o), masked to the size: s=0 keeps the low 8 bits, s=1 the low 16, else all 32. Upper bits are zero; sign extension is done downstream.
  - Then go to ACK.
- ACK: rw_valid_i=1 for exactly this cycle, then go to IDLE.
  - The upstream stage advances on this edge, so rw_valid_o still high in the following IDLE cycle is a new request.
- data_read_i changes only on a read's RRESP handshake. Writes leave it unchanged.
- Minimum latency, with ready/valid returned the cycle they are requested: accept cycle 0, address cycle 1, response cycle 2, ack cycle 3.
- AXI rule: valid outputs never drop before their handshake. Outputs are not combinationally dependent on ready inputs, except for the per-channel done flags.
- If rw_valid_o deasserts mid-transaction (flush): the transaction still completes and ack still pulses. Upstream ignores it.

Optional Feature:
- Macro: MMIO_ERR_TRAP_EN.
- Defined:
  - A nonzero bresp or rresp at handshake sets err_o=1 (sticky until rst).
  - err_addr_o captures the latched address on the first error only.
  - Read data on an error response is forced to 32'h0.
- Undefined: err_o and err_addr_o are tied 0; resp fields are ignored; rdata is passed unchanged.

Test Plan:
- Read addr 0xA000_0004, s=2; arready and rvalid immediate; rdata=0x1234_5678 -> araddr=0xA000_0004, rw_valid_i pulses in cycle 3, data_read_i=0x1234_5678 held afterwards.
- Write addr 0xA000_0003, s=0, data 0xAB -> wstrb=1000, wdata=0xAB00_0000, ack after bvalid.
- awready 3 cycles late, wready immediate -> wvalid drops after 1 cycle, awvalid stays high until its handshake, exactly one ack.
- Back-to-back: rw_valid_o held high across the ack with new addr 0xA000_0010 -> a second independent transaction is issued, with no duplicate of the first.
- Reset asserted in RRESP with rvalid low -> next cycle all valids are 0, no ack, data_read_i=0.
- With MMIO_ERR_TRAP_EN: rresp=2'b10 on read of 0xA000_0020 -> err_o=1, err_addr_o=0xA000_0020, data_read_i=0; a later error leaves err_addr_o unchanged.
